// File: rtl/regfile_read_scoreboard_if.sv
// Decode / register-file / writeback / execute signal bundle for the
// operand-read scoreboard. The master side is the surrounding pipeline,
// the slave side is the scoreboard itself.
interface regfile_read_scoreboard_if #(
    parameter int XLEN = 32
);
    // Decode request
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_rs1;
    logic [4:0]      req_rs2;
    logic [4:0]      req_rd;
    logic            req_rd_we;

    // Combinational register-file read of req_rs1/req_rs2
    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;

    // Writeback bus
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    // Registered operand stage towards execute
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [4:0]      out_rd;

    // Sticky scoreboard underflow flag
    logic            sb_err;

    modport master (
        output req_valid, req_rs1, req_rs2, req_rd, req_rd_we,
        output rf_rs1_data, rf_rs2_data,
        output wb_en, wb_addr, wb_data,
        output out_ready,
        input  req_ready, out_valid, out_rs1_val, out_rs2_val, out_rd, sb_err
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_rd, req_rd_we,
        input  rf_rs1_data, rf_rs2_data,
        input  wb_en, wb_addr, wb_data,
        input  out_ready,
        output req_ready, out_valid, out_rs1_val, out_rs2_val, out_rd, sb_err
    );
endinterface

// File: rtl/regfile_read_scoreboard.sv
// Operand-read scoreboard between decode and execute. Counts outstanding
// writebacks per architectural register, stalls decode until both sources
// are safe, forwards same-cycle writeback data, and hands the operands to
// execute through a single registered valid/ready stage.
module regfile_read_scoreboard #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    parameter int CNTW = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_read_scoreboard_if.slave bus
);
    localparam logic [CNTW-1:0] CntMax = '1;
    localparam logic [CNTW-1:0] CntOne = CNTW'(1);

    // Pending-writeback count per architectural register
    logic [CNTW-1:0] cnt [NREG];

    logic            src1Ready;
    logic            src2Ready;
    logic [XLEN-1:0] src1Val;
    logic [XLEN-1:0] src2Val;

    logic            decWb;
    logic            spuriousWb;
    logic            rdFull;
    logic            outFree;
    logic            reqReady;
    logic            accept;
    logic            incRd;

    logic            outValid;
    logic [XLEN-1:0] outRs1Val;
    logic [XLEN-1:0] outRs2Val;
    logic [4:0]      outRd;
    logic            sbErr;

    // A writeback retires one pending write only if one is outstanding;
    // otherwise it is an unexpected writeback and only raises the error flag.
    assign decWb      = bus.wb_en && (bus.wb_addr != '0) && (cnt[bus.wb_addr] != '0);
    assign spuriousWb = bus.wb_en && (bus.wb_addr != '0) && (cnt[bus.wb_addr] == '0);

    // Resolve each source from pre-update state: x0, clean register file, or forward
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // if/else chain leaves it unassigned and infers a latch.
        src1Ready = 1'b0;
        src1Val   = '0;
        src2Ready = 1'b0;
        src2Val   = '0;

        if (bus.req_rs1 == '0) begin
            src1Ready = 1'b1;
        end else if (cnt[bus.req_rs1] == '0) begin
            src1Ready = 1'b1;
            src1Val   = bus.rf_rs1_data;
        end else if ((cnt[bus.req_rs1] == CntOne) && bus.wb_en && (bus.wb_addr == bus.req_rs1)) begin
            src1Ready = 1'b1;
            src1Val   = bus.wb_data;
        end

        if (bus.req_rs2 == '0) begin
            src2Ready = 1'b1;
        end else if (cnt[bus.req_rs2] == '0) begin
            src2Ready = 1'b1;
            src2Val   = bus.rf_rs2_data;
        end else if ((cnt[bus.req_rs2] == CntOne) && bus.wb_en && (bus.wb_addr == bus.req_rs2)) begin
            src2Ready = 1'b1;
            src2Val   = bus.wb_data;
        end
    end

    // A saturated destination counter blocks issue unless it drains this cycle
    assign rdFull   = bus.req_rd_we && (bus.req_rd != '0) && (cnt[bus.req_rd] == CntMax) &&
                      !(decWb && (bus.wb_addr == bus.req_rd));
    assign outFree  = !outValid || bus.out_ready;
    assign reqReady = src1Ready && src2Ready && outFree && !rdFull;
    assign accept   = bus.req_valid && reqReady;
    assign incRd    = accept && bus.req_rd_we && (bus.req_rd != '0);

    // Per-register pending counters: +1 on issue, -1 on retire, net zero on both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counters are a small flop array holding architectural
            // hazard state, so they are cleared by reset like any other flop.
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if ((incRd && (bus.req_rd == 5'(i))) && !(decWb && (bus.wb_addr == 5'(i)))) begin
                    // NOTE: state uses <= so every flop samples pre-edge values and
                    // the counter, error and output updates are order-independent.
                    cnt[i] <= cnt[i] + CntOne;
                end else if (!(incRd && (bus.req_rd == 5'(i))) && (decWb && (bus.wb_addr == 5'(i)))) begin
                    cnt[i] <= cnt[i] - CntOne;
                end
            end
        end
    end

    // Sticky flag for a writeback that had nothing outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbErr <= 1'b0;
        end else if (spuriousWb) begin
            sbErr <= 1'b1;
        end
    end

    // Registered operand stage: load on accept, drop valid on consume, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid  <= 1'b0;
            outRs1Val <= '0;
            outRs2Val <= '0;
            outRd     <= '0;
        end else if (accept) begin
            outValid  <= 1'b1;
            outRs1Val <= src1Val;
            outRs2Val <= src2Val;
            outRd     <= bus.req_rd;
        end else if (bus.out_ready) begin
            outValid  <= 1'b0;
        end
    end

    assign bus.req_ready   = reqReady;
    assign bus.out_valid   = outValid;
    assign bus.out_rs1_val = outRs1Val;
    assign bus.out_rs2_val = outRs2Val;
    assign bus.out_rd      = outRd;
    assign bus.sb_err      = sbErr;
endmodule

// File: tb/tb_regfile_read_scoreboard.sv
// Self-checking bench for regfile_read_scoreboard: a directed vector table,
// hand-written reset / WAW / back-pressure sequences, and a random phase
// checked against a pending-write queue model.
module tb_regfile_read_scoreboard;
    localparam int XLEN    = 32;
    localparam int MaxPend = 3;

    logic clk;
    logic rst_n;

    regfile_read_scoreboard_if #(.XLEN(XLEN)) ifc ();

    regfile_read_scoreboard #(
        .NREG(32),
        .XLEN(XLEN),
        .CNTW(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // One directed cycle: inputs plus expected req_ready and post-edge outputs
    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [31:0] rf1, rf2;
        logic        wbE;
        logic [4:0]  wbA;
        logic [31:0] wbD;
        logic        oRdy;
        logic        eReady, eValid;
        logic [31:0] eRs1, eRs2;
        logic [4:0]  eRd;
        logic        eErr;
    } vec_t;

    function automatic vec_t mkVec(
        input logic [31:0] v, rs1, rs2, rd, we, rf1, rf2, wbE, wbA, wbD, oRdy,
        input logic [31:0] eReady, eValid, eRs1, eRs2, eRd, eErr);
        vec_t t;
        t.v = v[0];     t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.rd = rd[4:0];
        t.we = we[0];   t.rf1 = rf1;      t.rf2 = rf2;
        t.wbE = wbE[0]; t.wbA = wbA[4:0]; t.wbD = wbD;      t.oRdy = oRdy[0];
        t.eReady = eReady[0]; t.eValid = eValid[0];
        t.eRs1 = eRs1;  t.eRs2 = eRs2;    t.eRd = eRd[4:0]; t.eErr = eErr[0];
        return t;
    endfunction

    // Reference model: a queue of in-flight destination registers
    logic [4:0]  pend [$];
    logic [31:0] rfMem [32];
    logic        mValid;
    logic [31:0] mRs1, mRs2;
    logic [4:0]  mRd;
    logic        mErr;

    function automatic int pendCount(input logic [4:0] r);
        int n = 0;
        foreach (pend[i]) if (pend[i] == r) n++;
        return n;
    endfunction

    task automatic retireOne(input logic [4:0] r);
        foreach (pend[i]) begin
            if (pend[i] == r) begin
                pend.delete(i);
                return;
            end
        end
    endtask

    task automatic modelReset();
        pend.delete();
        mValid = 1'b0; mRs1 = '0; mRs2 = '0; mRd = '0; mErr = 1'b0;
    endtask

    task automatic idle();
        ifc.req_valid = 1'b0; ifc.req_rs1 = '0; ifc.req_rs2 = '0; ifc.req_rd = '0;
        ifc.req_rd_we = 1'b0; ifc.rf_rs1_data = '0; ifc.rf_rs2_data = '0;
        ifc.wb_en = 1'b0; ifc.wb_addr = '0; ifc.wb_data = '0; ifc.out_ready = 1'b1;
    endtask

    // Resolve one source from the model's view of outstanding writes
    task automatic resolveSrc(input logic [4:0] rs, input logic wbE, input logic [4:0] wbA,
                              input logic [31:0] wbD, output logic ok, output logic [31:0] val);
        int n;
        n = pendCount(rs);
        ok = 1'b0; val = '0;
        if (rs == 5'd0) begin
            ok = 1'b1;
        end else if (n == 0) begin
            ok = 1'b1; val = rfMem[rs];
        end else if (n == 1 && wbE && wbA == rs) begin
            ok = 1'b1; val = wbD;
        end
    endtask

    // Drive one cycle, compare against the model, then advance the model
    task automatic step(input string tag, input logic v, input logic [4:0] rs1, rs2, rd,
                        input logic we, input logic wbE, input logic [4:0] wbA,
                        input logic [31:0] wbD, input logic oRdy,
                        output logic gotReady, output logic [31:0] gotRs1);
        logic ok1, ok2, full, expReady, acc;
        logic [31:0] v1, v2;
        ifc.req_valid = v; ifc.req_rs1 = rs1; ifc.req_rs2 = rs2; ifc.req_rd = rd;
        ifc.req_rd_we = we; ifc.rf_rs1_data = rfMem[rs1]; ifc.rf_rs2_data = rfMem[rs2];
        ifc.wb_en = wbE; ifc.wb_addr = wbA; ifc.wb_data = wbD; ifc.out_ready = oRdy;

        resolveSrc(rs1, wbE, wbA, wbD, ok1, v1);
        resolveSrc(rs2, wbE, wbA, wbD, ok2, v2);
        full     = we && rd != 5'd0 && pendCount(rd) == MaxPend && !(wbE && wbA == rd);
        expReady = ok1 && ok2 && (!mValid || oRdy) && !full;

        @(negedge clk);
        gotReady = ifc.req_ready;
        check({tag, ".req_ready"}, 32'(gotReady), 32'(expReady));

        acc = v && expReady;
        if (acc) begin
            mValid = 1'b1; mRs1 = v1; mRs2 = v2; mRd = rd;
        end else if (oRdy) begin
            mValid = 1'b0;
        end
        if (wbE && wbA != 5'd0) begin
            if (pendCount(wbA) > 0) retireOne(wbA);
            else mErr = 1'b1;
            rfMem[wbA] = wbD;
        end
        if (acc && we && rd != 5'd0) pend.push_back(rd);

        @(posedge clk);
        #1;
        check({tag, ".out_valid"},   32'(ifc.out_valid), 32'(mValid));
        check({tag, ".out_rs1_val"}, ifc.out_rs1_val,    mRs1);
        check({tag, ".out_rs2_val"}, ifc.out_rs2_val,    mRs2);
        check({tag, ".out_rd"},      32'(ifc.out_rd),    32'(mRd));
        check({tag, ".sb_err"},      32'(ifc.sb_err),    32'(mErr));
        gotRs1 = ifc.out_rs1_val;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "simulation time limit reached");
    end

    vec_t        tbl [14];
    logic        gr;
    logic [31:0] g1;

    initial begin
        tbl[0]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tbl[1]  = mkVec(1, 1, 2, 0, 0, 'h11, 'h22, 0, 0, 0, 1,  1, 1, 'h11, 'h22, 0, 0);
        tbl[2]  = mkVec(1, 0, 0, 3, 1, 'hAA, 'hAA, 0, 0, 0, 1,  1, 1, 0, 0, 3, 0);
        tbl[3]  = mkVec(1, 3, 0, 0, 0, 'h33, 0, 0, 0, 0, 1,  0, 0, 0, 0, 3, 0);
        tbl[4]  = mkVec(1, 3, 0, 0, 0, 'h33, 0, 1, 3, 'hDEADBEEF, 1,  1, 1, 'hDEADBEEF, 0, 0, 0);
        tbl[5]  = mkVec(1, 3, 3, 0, 0, 'h12345678, 'h12345678, 0, 0, 0, 1,  1, 1, 'h12345678, 'h12345678, 0, 0);
        tbl[6]  = mkVec(1, 0, 0, 0, 1, 'h55, 'h66, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0);
        tbl[7]  = mkVec(1, 0, 5, 0, 1, 'h55, 'h77, 0, 0, 0, 1,  1, 1, 0, 'h77, 0, 0);
        tbl[8]  = mkVec(1, 6, 6, 6, 1, 'h66, 'h66, 0, 0, 0, 1,  1, 1, 'h66, 'h66, 6, 0);
        tbl[9]  = mkVec(1, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 1, 'h66, 'h66, 6, 0);
        tbl[10] = mkVec(0, 0, 0, 0, 0, 0, 0, 1, 7, 9, 0,  0, 1, 'h66, 'h66, 6, 1);
        tbl[11] = mkVec(1, 6, 0, 0, 0, 1, 0, 1, 6, 'hCAFE, 1,  1, 1, 'hCAFE, 0, 0, 1);
        tbl[12] = mkVec(0, 7, 0, 0, 0, 7, 0, 0, 0, 0, 1,  1, 0, 'hCAFE, 0, 0, 1);
        tbl[13] = mkVec(1, 7, 0, 0, 0, 'h70, 0, 0, 0, 0, 1,  1, 1, 'h70, 0, 0, 1);

        foreach (rfMem[i]) rfMem[i] = '0;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(ifc.out_valid), 32'd0);
        check("reset.out_rs1_val", ifc.out_rs1_val, 32'd0);
        check("reset.out_rs2_val", ifc.out_rs2_val, 32'd0);
        check("reset.out_rd", 32'(ifc.out_rd), 32'd0);
        check("reset.sb_err", 32'(ifc.sb_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            ifc.req_valid = tbl[i].v; ifc.req_rs1 = tbl[i].rs1; ifc.req_rs2 = tbl[i].rs2;
            ifc.req_rd = tbl[i].rd; ifc.req_rd_we = tbl[i].we;
            ifc.rf_rs1_data = tbl[i].rf1; ifc.rf_rs2_data = tbl[i].rf2;
            ifc.wb_en = tbl[i].wbE; ifc.wb_addr = tbl[i].wbA; ifc.wb_data = tbl[i].wbD;
            ifc.out_ready = tbl[i].oRdy;
            @(negedge clk);
            check($sformatf("vec%0d.req_ready", i), 32'(ifc.req_ready), 32'(tbl[i].eReady));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.out_valid", i), 32'(ifc.out_valid), 32'(tbl[i].eValid));
            check($sformatf("vec%0d.out_rs1_val", i), ifc.out_rs1_val, tbl[i].eRs1);
            check($sformatf("vec%0d.out_rs2_val", i), ifc.out_rs2_val, tbl[i].eRs2);
            check($sformatf("vec%0d.out_rd", i), 32'(ifc.out_rd), 32'(tbl[i].eRd));
            check($sformatf("vec%0d.sb_err", i), 32'(ifc.sb_err), 32'(tbl[i].eErr));
        end

        // Sync model with the state the table leaves behind
        pend.delete();
        mValid = 1'b1; mRs1 = 32'h70; mRs2 = '0; mRd = '0; mErr = 1'b1;

        // Reset mid-transfer with two writes pending on x5
        step("rst_issue5a", 1, 0, 0, 5, 1, 0, 0, 0, 1, gr, g1);
        step("rst_issue5b", 1, 0, 0, 5, 1, 0, 0, 0, 1, gr, g1);
        step("rst_read5", 1, 5, 0, 0, 0, 0, 0, 0, 1, gr, g1);
        check("rst_read5_stalled", 32'(gr), 32'd0);
        step("rst_fill", 1, 1, 0, 0, 0, 0, 0, 0, 1, gr, g1);
        idle();
        ifc.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_mid.out_rs1_val", ifc.out_rs1_val, 32'd0);
        check("rst_mid.out_rs2_val", ifc.out_rs2_val, 32'd0);
        check("rst_mid.out_rd", 32'(ifc.out_rd), 32'd0);
        check("rst_mid.sb_err", 32'(ifc.sb_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        modelReset();
        step("rst_after5", 1, 5, 5, 0, 0, 0, 0, 0, 1, gr, g1);
        check("rst_after5_ready", 32'(gr), 32'd1);

        // WAW depth on x4
        for (int k = 0; k < 3; k++) begin
            step($sformatf("waw_issue%0d", k), 1, 0, 0, 4, 1, 0, 0, 0, 1, gr, g1);
            check($sformatf("waw_issue%0d_ready", k), 32'(gr), 32'd1);
        end
        step("waw_full", 1, 0, 0, 4, 1, 0, 0, 0, 1, gr, g1);
        check("waw_full_stalled", 32'(gr), 32'd0);
        step("waw_reader_cnt3", 1, 4, 0, 0, 0, 0, 0, 0, 1, gr, g1);
        check("waw_reader_cnt3_stalled", 32'(gr), 32'd0);
        step("waw_full_drain", 1, 0, 0, 4, 1, 1, 4, 32'hA0A0A0A0, 1, gr, g1);
        check("waw_full_drain_ready", 32'(gr), 32'd1);
        step("waw_wb_cnt3", 1, 4, 0, 0, 0, 1, 4, 32'hB1B1B1B1, 1, gr, g1);
        check("waw_wb_cnt3_stalled", 32'(gr), 32'd0);
        step("waw_wb_cnt2", 1, 4, 0, 0, 0, 1, 4, 32'hC2C2C2C2, 1, gr, g1);
        check("waw_wb_cnt2_stalled", 32'(gr), 32'd0);
        step("waw_wb_cnt1", 1, 4, 0, 0, 0, 1, 4, 32'hD3D3D3D3, 1, gr, g1);
        check("waw_wb_cnt1_ready", 32'(gr), 32'd1);
        check("waw_forward_val", g1, 32'hD3D3D3D3);

        // x0 issue followed by three cycles of back-pressure
        step("bp_fill", 1, 0, 0, 0, 1, 0, 0, 0, 1, gr, g1);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("bp_hold%0d", k), 1, 0, 0, 0, 1, 0, 0, 0, 0, gr, g1);
            check($sformatf("bp_hold%0d_stalled", k), 32'(gr), 32'd0);
        end
        step("bp_release", 1, 0, 2, 0, 1, 0, 0, 0, 1, gr, g1);
        check("bp_release_ready", 32'(gr), 32'd1);

        // Random traffic against the queue model
        for (int n = 0; n < 1500; n++) begin
            logic        v, we, wbE, oRdy;
            logic [4:0]  rs1, rs2, rd, wbA;
            logic [31:0] wbD;
            int          idx;
            v    = ($urandom_range(9, 0) < 7);
            rs1  = 5'($urandom_range(7, 0));
            rs2  = 5'($urandom_range(7, 0));
            rd   = 5'($urandom_range(7, 0));
            we   = 1'($urandom_range(1, 0));
            oRdy = ($urandom_range(3, 0) != 0);
            wbD  = $urandom;
            wbA  = 5'($urandom_range(31, 0));
            wbE  = 1'b0;
            if (pend.size() > 0 && $urandom_range(1, 0) == 1) begin
                idx = int'($urandom_range(32'(pend.size() - 1), 0));
                wbE = 1'b1;
                wbA = pend[idx];
            end else if ($urandom_range(99, 0) == 0) begin
                wbE = 1'b1;
                wbA = 5'($urandom_range(31, 1));
            end
            step("rand", v, rs1, rs2, rd, we, wbE, wbA, wbD, oRdy, gr, g1);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
